// File: rtl/nibble_serializer.sv
// Purpose: serializes one {data1,data2} word into NIBBLES nibbles, least significant nibble first.
// Latency: first nibble is valid 1 cycle after word acceptance; back-to-back words stream with no bubble.
// Backpressure: out_ready low freezes the current nibble; in_ready only opens in IDLE or on the final nibble transfer.
module nibble_serializer #(
  parameter  int FIELD_W = 16,
  parameter  int NIB_W   = 4,
  parameter  int CNT_W   = 16,
  localparam int WORD_W  = 2 * FIELD_W,
  localparam int NIBBLES = WORD_W / NIB_W,
  localparam int IDX_W   = $clog2(NIBBLES)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [FIELD_W-1:0] in_data1,
  input  logic [FIELD_W-1:0] in_data2,
  output logic               in_ready,
  output logic               out_valid,
  output logic [NIB_W-1:0]   out_nibble,
  output logic [IDX_W-1:0]   out_idx,
  output logic               out_last,
  input  logic               out_ready,
  output logic [CNT_W-1:0]   words_sent
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                at_last;
  logic                out_xfer;
  logic                accept;

  assign at_last  = (state_q == SEND) && (idx_q == LAST_IDX);
  assign out_xfer = (state_q == SEND) && out_ready;
  // Gated by rst_n so the producer never sees ready while the block is held in reset.
  assign in_ready = rst_n && ((state_q == IDLE) || (at_last && out_ready));
  assign accept   = in_valid && in_ready;

  // Outputs come straight from registered state, so nothing combinational reaches out_nibble from in_data*.
  assign out_valid  = (state_q == SEND);
  assign out_nibble = word_q[NIB_W*idx_q +: NIB_W];
  assign out_idx    = idx_q;
  assign out_last   = at_last;
  assign words_sent = cnt_q;

  // Next-state logic: load on accept, step idx per transfer, count and reload or idle on the last nibble.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          word_d  = {in_data1, in_data2};
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (out_xfer) begin
          if (at_last) begin
            cnt_d = cnt_q + CNT_W'(1);
            idx_d = '0;
            if (accept) begin
              word_d  = {in_data1, in_data2};
              state_d = SEND;
            end else begin
              state_d = IDLE;
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; an asynchronous reset drops any partial word immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      word_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_nibble_serializer.sv
// Testbench for nibble_serializer: directed scenarios plus random traffic against a nibble-queue model.
// The model expands every accepted word into its remaining nibbles and pops one per consumer transfer.
// Outputs are sampled on the falling edge; inputs change 1 time unit after the rising edge.
module tb_nibble_serializer;

  typedef struct {
    logic [3:0] nib;
    logic [2:0] idx;
    logic       last;
  } nib_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data1 = '0;
  logic [15:0] in_data2 = '0;
  logic        in_ready;
  logic        out_valid;
  logic [3:0]  out_nibble;
  logic [2:0]  out_idx;
  logic        out_last;
  logic        out_ready = 1'b0;
  logic [15:0] words_sent;

  int checks = 0;
  int errors = 0;

  nib_t        model_q[$];
  logic [15:0] model_cnt = '0;
  logic [31:0] stream = '0;
  logic        last_accept = 1'b0;

  nibble_serializer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data1   (in_data1),
    .in_data2   (in_data2),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_nibble (out_nibble),
    .out_idx    (out_idx),
    .out_last   (out_last),
    .out_ready  (out_ready),
    .words_sent (words_sent)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: compare against the model at negedge, advance the model, return 1 unit after posedge.
  task automatic step();
    logic       exp_rdy;
    logic       out_fire;
    logic       in_fire;
    logic [31:0] w;
    nib_t       n;
    @(negedge clk);
    exp_rdy = (model_q.size() == 0) || (model_q.size() == 1 && out_ready);
    check("out_valid", 32'(out_valid), 32'(model_q.size() != 0));
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    check("words_sent", 32'(words_sent), 32'(model_cnt));
    if (model_q.size() != 0) begin
      check("out_nibble", 32'(out_nibble), 32'(model_q[0].nib));
      check("out_idx", 32'(out_idx), 32'(model_q[0].idx));
      check("out_last", 32'(out_last), 32'(model_q[0].last));
    end
    out_fire = (model_q.size() != 0) && out_ready;
    in_fire  = in_valid && exp_rdy;
    if (out_fire) begin
      stream = {out_nibble, stream[31:4]};
      n = model_q.pop_front();
      if (n.last) model_cnt = model_cnt + 16'd1;
    end
    if (in_fire) begin
      w = {in_data1, in_data2};
      for (int i = 0; i < 8; i++) begin
        n.nib  = 4'((w >> (4 * i)) & 32'hF);
        n.idx  = 3'(i);
        n.last = (i == 7);
        model_q.push_back(n);
      end
    end
    last_accept = in_fire;
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] w);
    in_data1 = w[31:16];
    in_data2 = w[15:0];
    in_valid = 1'b1;
  endtask

  // Steps until the model has nothing left to send; a blown budget counts as a failure.
  task automatic drain();
    int budget = 200;
    in_valid = 1'b0;
    while (model_q.size() != 0 && budget > 0) begin
      step();
      budget--;
    end
    if (budget == 0) check("drain_timeout", 0, 1);
    step();
  endtask

  task automatic wait_accept();
    int budget = 100;
    do begin
      step();
      budget--;
    end while (!last_accept && budget > 0);
    if (!last_accept) check("accept_timeout", 0, 1);
  endtask

  initial begin
    int budget;

    // Reset values
    #3;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_out_nibble", 32'(out_nibble), 0);
    check("rst_out_idx", 32'(out_idx), 0);
    check("rst_out_last", 32'(out_last), 0);
    check("rst_words_sent", 32'(words_sent), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single word, free-running consumer
    out_ready = 1'b1;
    offer(32'h1234ABCD);
    wait_accept();
    drain();
    check("word1_stream", stream, 32'h1234ABCD);
    check("word1_count", 32'(words_sent), 1);

    // Two words back to back with in_valid held
    offer(32'h1234ABCD);
    wait_accept();
    offer(32'h00FF5A5A);
    wait_accept();
    drain();
    check("b2b_stream", stream, 32'h00FF5A5A);
    check("b2b_count", 32'(words_sent), 3);

    // Consumer stall for 3 cycles at idx 2
    offer(32'hDEADBEEF);
    wait_accept();
    in_valid = 1'b0;
    budget = 20;
    while ((model_q.size() == 0 || model_q[0].idx != 3'd2) && budget > 0) begin
      step();
      budget--;
    end
    if (budget == 0) check("stall_timeout", 0, 1);
    out_ready = 1'b0;
    repeat (3) step();
    check("stall_nibble", 32'(out_nibble), 32'hE);
    check("stall_idx", 32'(out_idx), 2);
    out_ready = 1'b1;
    drain();
    check("stall_stream", stream, 32'hDEADBEEF);

    // Asynchronous reset at idx 4, between clock edges
    offer(32'hCAFEF00D);
    wait_accept();
    in_valid = 1'b0;
    budget = 20;
    while ((model_q.size() == 0 || model_q[0].idx != 3'd4) && budget > 0) begin
      step();
      budget--;
    end
    if (budget == 0) check("areset_timeout", 0, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("areset_out_valid", 32'(out_valid), 0);
    check("areset_out_idx", 32'(out_idx), 0);
    check("areset_out_last", 32'(out_last), 0);
    check("areset_out_nibble", 32'(out_nibble), 0);
    check("areset_words_sent", 32'(words_sent), 0);
    check("areset_in_ready", 32'(in_ready), 0);
    model_q.delete();
    model_cnt = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    offer(32'h00000001);
    wait_accept();
    drain();
    check("post_reset_stream", stream, 32'h00000001);

    // Counter wrap from all ones
    force dut.cnt_q = 16'hFFFF;
    #1;
    release dut.cnt_q;
    model_cnt = 16'hFFFF;
    offer(32'h87654321);
    wait_accept();
    drain();
    check("wrap_count", 32'(words_sent), 0);

    // Inputs wiggle while SEND is busy; only accepted values may appear
    offer(32'h0F1E2D3C);
    wait_accept();
    repeat (10) begin
      in_data1 = 16'($urandom);
      in_data2 = 16'($urandom);
      step();
    end
    drain();

    // Random traffic and backpressure
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data1  = 16'($urandom);
      in_data2  = 16'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    out_ready = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
